// File: rtl/xgmii_baser_dec_64_if.sv
// Bus bundle between a 64b/66b block source and the XGMII decoder.
// The master drives the encoded block stream, and the slave returns decoded XGMII plus error status.
interface xgmii_baser_dec_64_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] encoded_rx_data;
  logic [HDR_WIDTH-1:0]  encoded_rx_hdr;
  logic                  err_count_clr;
  logic [DATA_WIDTH-1:0] xgmii_rxd;
  logic [CTRL_WIDTH-1:0] xgmii_rxc;
  logic                  rx_bad_block;
  logic                  rx_sequence_error;
  logic [7:0]            err_count;

  modport master (
    output encoded_rx_data, encoded_rx_hdr, err_count_clr,
    input  xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error, err_count
  );

  modport slave (
    input  encoded_rx_data, encoded_rx_hdr, err_count_clr,
    output xgmii_rxd, xgmii_rxc, rx_bad_block, rx_sequence_error, err_count
  );
endinterface

// File: rtl/xgmii_baser_dec_64.sv
// 10GBASE-R 64b/66b block decoder to 64-bit XGMII with frame-sequence checking.
// The decoder has a single registered output stage and keeps a saturating error counter.
module xgmii_baser_dec_64 #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = 2
) (
  input logic                clk,
  input logic                rst,
  xgmii_baser_dec_64_if.slave bus
);

  if (DATA_WIDTH != 64) begin : g_chk_dw
    $error("xgmii_baser_dec_64: DATA_WIDTH must be 64");
  end
  if (CTRL_WIDTH != 8) begin : g_chk_cw
    $error("xgmii_baser_dec_64: CTRL_WIDTH must be DATA_WIDTH/8");
  end
  if (HDR_WIDTH != 2) begin : g_chk_hw
    $error("xgmii_baser_dec_64: HDR_WIDTH must be 2");
  end

  localparam logic [DATA_WIDTH-1:0] ERR_BLK  = {CTRL_WIDTH{8'hFE}};
  localparam logic [DATA_WIDTH-1:0] IDLE_BLK = {CTRL_WIDTH{8'h07}};

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;
  typedef enum logic [2:0] {K_BAD, K_DATA, K_START, K_TERM, K_CTRL} kind_t;

  // Returns {invalid, xgmii_byte} for a 7-bit 10GBASE-R control code.
  function automatic logic [8:0] dec_ctrl(input logic [6:0] code);
    case (code)
      7'h00:   return {1'b0, 8'h07};
      7'h06:   return {1'b0, 8'h06};
      7'h1E:   return {1'b0, 8'hFE};
      7'h2D:   return {1'b0, 8'h1C};
      7'h33:   return {1'b0, 8'h3C};
      7'h4B:   return {1'b0, 8'h7C};
      7'h55:   return {1'b0, 8'hBC};
      7'h66:   return {1'b0, 8'hDC};
      7'h78:   return {1'b0, 8'hF7};
      default: return {1'b1, 8'hFE};
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] tdat;
  logic [7:0]            lane_code [CTRL_WIDTH];
  logic [CTRL_WIDTH-1:0] lane_cbad;
  logic [CTRL_WIDTH-1:0] cmask;
  logic                  obad;
  logic                  is_term;
  logic [2:0]            tpos;
  logic [DATA_WIDTH-1:0] dec_rxd_p0;
  logic [CTRL_WIDTH-1:0] dec_rxc_p0;
  kind_t                 kind_p0;

  logic [DATA_WIDTH-1:0] rxd_p0, rxd_p1;
  logic [CTRL_WIDTH-1:0] rxc_p0, rxc_p1;
  logic                  bad_p0, bad_p1;
  logic                  seq_p0, seq_p1;
  logic                  err_p0;
  logic [7:0]            cnt_nxt, cnt_p1;
  state_t                state, state_nxt;

  assign d    = bus.encoded_rx_data;
  // Terminate blocks carry lane-0 data in payload byte 1, so lane i data sits at byte i+1.
  assign tdat = {8'h00, d[DATA_WIDTH-1:8]};

  // ---- p0: block decode ----
  always_comb begin
    dec_rxd_p0 = ERR_BLK;
    dec_rxc_p0 = '1;
    kind_p0    = K_BAD;
    cmask      = '0;
    obad       = 1'b0;
    is_term    = 1'b0;
    tpos       = 3'd0;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      {lane_cbad[k], lane_code[k]} = dec_ctrl(d[7*k+8 +: 7]);
    end
    case (bus.encoded_rx_hdr)
      2'b10: begin
        kind_p0    = K_DATA;
        dec_rxd_p0 = d;
        dec_rxc_p0 = '0;
      end
      2'b01: begin
        case (d[7:0])
          8'h1E: begin
            kind_p0 = K_CTRL;
            cmask   = '1;
            for (int k = 0; k < CTRL_WIDTH; k++) dec_rxd_p0[8*k +: 8] = lane_code[k];
          end
          8'h78: begin
            kind_p0    = K_START;
            dec_rxd_p0 = {d[63:8], 8'hFB};
            dec_rxc_p0 = 8'h01;
          end
          8'h33: begin
            kind_p0    = K_START;
            cmask      = 8'h0F;
            dec_rxd_p0 = {d[63:40], 8'hFB, lane_code[3], lane_code[2], lane_code[1], lane_code[0]};
            dec_rxc_p0 = 8'h1F;
          end
          8'h66: begin
            kind_p0    = K_START;
            obad       = (d[35:32] != 4'h0);
            dec_rxd_p0 = {d[63:40], 8'hFB, d[31:8], 8'h9C};
            dec_rxc_p0 = 8'h11;
          end
          8'h55: begin
            kind_p0    = K_CTRL;
            obad       = (d[39:32] != 8'h00);
            dec_rxd_p0 = {d[63:40], 8'h9C, d[31:8], 8'h9C};
            dec_rxc_p0 = 8'h11;
          end
          8'h2D: begin
            kind_p0    = K_CTRL;
            cmask      = 8'h0F;
            obad       = (d[39:36] != 4'h0);
            dec_rxd_p0 = {d[63:40], 8'h9C, lane_code[3], lane_code[2], lane_code[1], lane_code[0]};
            dec_rxc_p0 = 8'h1F;
          end
          8'h4B: begin
            kind_p0    = K_CTRL;
            cmask      = 8'hF0;
            obad       = (d[35:32] != 4'h0);
            dec_rxd_p0 = {lane_code[7], lane_code[6], lane_code[5], lane_code[4], d[31:8], 8'h9C};
            dec_rxc_p0 = 8'hF1;
          end
          8'h87: begin is_term = 1'b1; tpos = 3'd0; end
          8'h99: begin is_term = 1'b1; tpos = 3'd1; end
          8'hAA: begin is_term = 1'b1; tpos = 3'd2; end
          8'hB4: begin is_term = 1'b1; tpos = 3'd3; end
          8'hCC: begin is_term = 1'b1; tpos = 3'd4; end
          8'hD2: begin is_term = 1'b1; tpos = 3'd5; end
          8'hE1: begin is_term = 1'b1; tpos = 3'd6; end
          8'hFF: begin is_term = 1'b1; tpos = 3'd7; end
          default: kind_p0 = K_BAD;
        endcase
      end
      default: kind_p0 = K_BAD;
    endcase

    if (is_term) begin
      kind_p0 = K_TERM;
      for (int i = 0; i < CTRL_WIDTH; i++) begin
        if (i < int'(tpos)) begin
          dec_rxd_p0[8*i +: 8] = tdat[8*i +: 8];
          dec_rxc_p0[i]        = 1'b0;
        end else if (i == int'(tpos)) begin
          dec_rxd_p0[8*i +: 8] = 8'hFD;
          dec_rxc_p0[i]        = 1'b1;
        end else begin
          dec_rxd_p0[8*i +: 8] = lane_code[i];
          dec_rxc_p0[i]        = 1'b1;
          cmask[i]             = 1'b1;
        end
      end
    end

    // A bad O field voids the whole block; a bad control code only marks its own lane FE.
    if (obad) begin
      kind_p0    = K_BAD;
      dec_rxd_p0 = ERR_BLK;
      dec_rxc_p0 = '1;
    end else if (|(cmask & lane_cbad)) begin
      kind_p0 = K_BAD;
    end
  end

  // ---- frame FSM: state register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---- frame FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (kind_p0)
      K_BAD:          state_nxt = IDLE;
      K_START:        state_nxt = FRAME;
      K_TERM, K_CTRL: state_nxt = IDLE;
      default:        state_nxt = state;
    endcase
  end

  // ---- frame FSM: outputs ----
  always_comb begin
    rxd_p0 = dec_rxd_p0;
    rxc_p0 = dec_rxc_p0;
    bad_p0 = 1'b0;
    seq_p0 = 1'b0;
    case (kind_p0)
      K_BAD: bad_p0 = 1'b1;
      K_DATA, K_TERM: begin
        if (state == IDLE) begin
          rxd_p0 = ERR_BLK;
          rxc_p0 = '1;
          seq_p0 = 1'b1;
        end
      end
      K_START, K_CTRL: seq_p0 = (state == FRAME);
      default: ;
    endcase
  end

  assign err_p0  = bad_p0 | seq_p0;
  assign cnt_nxt = bus.err_count_clr ? {7'd0, err_p0} : (err_p0 ? sat_inc(cnt_p1) : cnt_p1);

  // ---- p1: registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_p1 <= IDLE_BLK;
      rxc_p1 <= '1;
      bad_p1 <= 1'b0;
      seq_p1 <= 1'b0;
      cnt_p1 <= 8'h00;
    end else begin
      rxd_p1 <= rxd_p0;
      rxc_p1 <= rxc_p0;
      bad_p1 <= bad_p0;
      seq_p1 <= seq_p0;
      cnt_p1 <= cnt_nxt;
    end
  end

  assign bus.xgmii_rxd         = rxd_p1;
  assign bus.xgmii_rxc         = rxc_p1;
  assign bus.rx_bad_block      = bad_p1;
  assign bus.rx_sequence_error = seq_p1;
  assign bus.err_count         = cnt_p1;

endmodule

// File: tb/tb_xgmii_baser_dec_64.sv
// Directed bench for xgmii_baser_dec_64: decode, frame sequencing, error counting and reset.
module tb_xgmii_baser_dec_64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [63:0] ERR  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] IDL  = 64'h0707070707070707;
  localparam logic [63:0] STRT = 64'h0102030405060778;

  xgmii_baser_dec_64_if bus ();
  xgmii_baser_dec_64 dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Present one block, let it pass the output register, then sample 1 ns after the edge.
  task automatic step(input logic [1:0] h, input logic [63:0] dd, input logic c);
    bus.encoded_rx_hdr  = h;
    bus.encoded_rx_data = dd;
    bus.err_count_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.encoded_rx_hdr = 2'b01; bus.encoded_rx_data = 64'h1E; bus.err_count_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++; if (bus.xgmii_rxd !== IDL) begin n_fail++; $display("FAIL reset_rxd: got %h want %h", bus.xgmii_rxd, IDL); end
    n_assert++; if (bus.xgmii_rxc !== 8'hFF) begin n_fail++; $display("FAIL reset_rxc: got %h want ff", bus.xgmii_rxc); end
    n_assert++; if (bus.rx_bad_block !== 1'b0) begin n_fail++; $display("FAIL reset_bad: got %b want 0", bus.rx_bad_block); end
    n_assert++; if (bus.rx_sequence_error !== 1'b0) begin n_fail++; $display("FAIL reset_seq: got %b want 0", bus.rx_sequence_error); end
    n_assert++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h want 00", bus.err_count); end
    #2 rst = 1'b1;
  endtask

  task automatic test_idle();
    step(2'b01, 64'h000000000000001E, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== IDL) begin n_fail++; $display("FAIL idle_rxd: got %h want %h", bus.xgmii_rxd, IDL); end
    n_assert++; if (bus.xgmii_rxc !== 8'hFF) begin n_fail++; $display("FAIL idle_rxc: got %h want ff", bus.xgmii_rxc); end
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b00) begin n_fail++; $display("FAIL idle_err: got %b want 00", {bus.rx_bad_block, bus.rx_sequence_error}); end
  endtask

  task automatic test_frame();
    step(2'b01, STRT, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== 64'h01020304050607FB) begin n_fail++; $display("FAIL frame_start_rxd: got %h want 01020304050607fb", bus.xgmii_rxd); end
    n_assert++; if (bus.xgmii_rxc !== 8'h01) begin n_fail++; $display("FAIL frame_start_rxc: got %h want 01", bus.xgmii_rxc); end
    step(2'b10, 64'h1122334455667788, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== 64'h1122334455667788) begin n_fail++; $display("FAIL frame_data_rxd: got %h want 1122334455667788", bus.xgmii_rxd); end
    n_assert++; if (bus.xgmii_rxc !== 8'h00) begin n_fail++; $display("FAIL frame_data_rxc: got %h want 00", bus.xgmii_rxc); end
    step(2'b01, 64'h000000DDCCBBAACC, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== 64'h070707FDDDCCBBAA) begin n_fail++; $display("FAIL frame_term_rxd: got %h want 070707fdddccbbaa", bus.xgmii_rxd); end
    n_assert++; if (bus.xgmii_rxc !== 8'hF0) begin n_fail++; $display("FAIL frame_term_rxc: got %h want f0", bus.xgmii_rxc); end
    // Ordered set 0x4B is only error-free when the frame has closed.
    step(2'b01, 64'h000000003322114B, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== 64'h070707073322119C) begin n_fail++; $display("FAIL os4b_rxd: got %h want 070707073322119c", bus.xgmii_rxd); end
    n_assert++; if (bus.xgmii_rxc !== 8'hF1) begin n_fail++; $display("FAIL os4b_rxc: got %h want f1", bus.xgmii_rxc); end
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b00) begin n_fail++; $display("FAIL frame_err: got %b want 00", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL frame_cnt: got %h want 00", bus.err_count); end
  endtask

  task automatic test_data_in_idle();
    step(2'b10, 64'hDEADBEEFCAFEF00D, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== ERR) begin n_fail++; $display("FAIL dii_rxd: got %h want %h", bus.xgmii_rxd, ERR); end
    n_assert++; if (bus.xgmii_rxc !== 8'hFF) begin n_fail++; $display("FAIL dii_rxc: got %h want ff", bus.xgmii_rxc); end
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b01) begin n_fail++; $display("FAIL dii_err: got %b want 01", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.err_count !== 8'h01) begin n_fail++; $display("FAIL dii_cnt: got %h want 01", bus.err_count); end
  endtask

  task automatic test_bad_hdr();
    step(2'b01, STRT, 1'b0);
    step(2'b11, 64'h1122334455667788, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== ERR) begin n_fail++; $display("FAIL badhdr_rxd: got %h want %h", bus.xgmii_rxd, ERR); end
    n_assert++; if (bus.xgmii_rxc !== 8'hFF) begin n_fail++; $display("FAIL badhdr_rxc: got %h want ff", bus.xgmii_rxc); end
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b10) begin n_fail++; $display("FAIL badhdr_err: got %b want 10", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.err_count !== 8'h02) begin n_fail++; $display("FAIL badhdr_cnt: got %h want 02", bus.err_count); end
    step(2'b10, 64'h1122334455667788, 1'b0);
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b01) begin n_fail++; $display("FAIL badhdr_next_err: got %b want 01", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.err_count !== 8'h03) begin n_fail++; $display("FAIL badhdr_next_cnt: got %h want 03", bus.err_count); end
  endtask

  task automatic test_back_to_back();
    step(2'b01, STRT, 1'b0);
    n_assert++; if (bus.rx_sequence_error !== 1'b0) begin n_fail++; $display("FAIL b2b_first_seq: got %b want 0", bus.rx_sequence_error); end
    step(2'b01, STRT, 1'b0);
    n_assert++; if (bus.rx_sequence_error !== 1'b1) begin n_fail++; $display("FAIL b2b_second_seq: got %b want 1", bus.rx_sequence_error); end
    n_assert++; if (bus.xgmii_rxd !== 64'h01020304050607FB) begin n_fail++; $display("FAIL b2b_second_rxd: got %h want 01020304050607fb", bus.xgmii_rxd); end
    step(2'b01, 64'h000000000000001E, 1'b0);
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b01) begin n_fail++; $display("FAIL ctrl_in_frame_err: got %b want 01", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.xgmii_rxd !== IDL) begin n_fail++; $display("FAIL ctrl_in_frame_rxd: got %h want %h", bus.xgmii_rxd, IDL); end
    step(2'b10, 64'h0, 1'b0);
    n_assert++; if (bus.rx_sequence_error !== 1'b1) begin n_fail++; $display("FAIL ctrl_left_idle_seq: got %b want 1", bus.rx_sequence_error); end
    n_assert++; if (bus.err_count !== 8'h06) begin n_fail++; $display("FAIL b2b_cnt: got %h want 06", bus.err_count); end
  endtask

  task automatic test_bad_codes();
    step(2'b01, 64'h000000000040001E, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== 64'h0707070707FE0707) begin n_fail++; $display("FAIL badcode_rxd: got %h want 0707070707fe0707", bus.xgmii_rxd); end
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b10) begin n_fail++; $display("FAIL badcode_err: got %b want 10", {bus.rx_bad_block, bus.rx_sequence_error}); end
    step(2'b01, 64'h0000000100000055, 1'b0);
    n_assert++; if (bus.xgmii_rxd !== ERR) begin n_fail++; $display("FAIL bad_ofield_rxd: got %h want %h", bus.xgmii_rxd, ERR); end
    n_assert++; if (bus.rx_bad_block !== 1'b1) begin n_fail++; $display("FAIL bad_ofield_bad: got %b want 1", bus.rx_bad_block); end
    step(2'b01, 64'h0000000000000012, 1'b0);
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b10) begin n_fail++; $display("FAIL bad_type_err: got %b want 10", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.err_count !== 8'h09) begin n_fail++; $display("FAIL badcode_cnt: got %h want 09", bus.err_count); end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 300; i++) step(2'b11, 64'h0, 1'b0);
    n_assert++; if (bus.err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_cnt: got %h want ff", bus.err_count); end
    step(2'b00, 64'h0, 1'b1);
    n_assert++; if (bus.err_count !== 8'h01) begin n_fail++; $display("FAIL clr_with_err_cnt: got %h want 01", bus.err_count); end
    step(2'b01, 64'h000000000000001E, 1'b1);
    n_assert++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL clr_no_err_cnt: got %h want 00", bus.err_count); end
  endtask

  task automatic test_reset_mid_frame();
    step(2'b11, 64'h0, 1'b0);
    step(2'b01, STRT, 1'b0);
    n_assert++; if (bus.err_count !== 8'h01) begin n_fail++; $display("FAIL pre_rst_cnt: got %h want 01", bus.err_count); end
    #3 rst = 1'b0;
    #1;
    n_assert++; if (bus.xgmii_rxd !== IDL) begin n_fail++; $display("FAIL async_rst_rxd: got %h want %h", bus.xgmii_rxd, IDL); end
    n_assert++; if (bus.xgmii_rxc !== 8'hFF) begin n_fail++; $display("FAIL async_rst_rxc: got %h want ff", bus.xgmii_rxc); end
    n_assert++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL async_rst_cnt: got %h want 00", bus.err_count); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step(2'b01, 64'h07060504030201FF, 1'b0);
    n_assert++; if ({bus.rx_bad_block, bus.rx_sequence_error} !== 2'b01) begin n_fail++; $display("FAIL term_after_rst_err: got %b want 01", {bus.rx_bad_block, bus.rx_sequence_error}); end
    n_assert++; if (bus.xgmii_rxd !== ERR) begin n_fail++; $display("FAIL term_after_rst_rxd: got %h want %h", bus.xgmii_rxd, ERR); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_data_in_idle();
    test_bad_hdr();
    test_back_to_back();
    test_bad_codes();
    test_err_sat();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
